// File: rtl/frogger_pkg.sv
//------------------------------------------------------------------------------
// frogger_pkg : shared types and constants for the frogger game blocks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package frogger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } issuer_state_t;

    localparam int TENS_MAX = 9;

endpackage

`default_nettype wire

// File: rtl/edge_rise.sv
//------------------------------------------------------------------------------
// edge_rise : registers a level input and flags its rising edge.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_rise (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else if (clear_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

`default_nettype wire

// File: rtl/point_issuer.sv
//------------------------------------------------------------------------------
// point_issuer : converts goal/bonus events into spaced scoreboard point pulses
//                and keeps a saturating binary tens count from overflow pulses.
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module point_issuer #(
    parameter int PTS_PER_GOAL = 1,
    parameter int BONUS_PTS    = 3,
    parameter int MAX_PENDING  = 15,
    parameter int GAP          = 2,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             goal,
    input  logic             bonus,
    input  logic             overflow,
    output logic             point,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic [3:0]       tens,
    output logic             maxed,
    output logic             dropped
);

    import frogger_pkg::*;

    localparam int SW = CNT_W + 2;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [SW-1:0] MAX_S    = SW'(MAX_PENDING);
    localparam logic [SW-1:0] GOAL_S   = SW'(PTS_PER_GOAL);
    localparam logic [SW-1:0] BONUS_S  = SW'(BONUS_PTS);
    localparam logic [3:0]    TENS_TOP = 4'(TENS_MAX);

    issuer_state_t    state_q, state_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [3:0]       tens_q, tens_d;
    logic             dropped_q, dropped_d;
    logic             goal_rise;
    logic [SW-1:0]    add;
    logic [SW-1:0]    sum;

    edge_rise u_goal_rise (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (clear),
        .d_i     (goal),
        .rise_o  (goal_rise)
    );

    // Wide sum so the saturation compare sees the true total before clipping.
    always_comb begin
        add       = (goal_rise ? GOAL_S : '0) + (bonus ? BONUS_S : '0);
        sum       = {2'b00, pending_q} + add
                    - ((state_q == frogger_pkg::ISSUE) ? SW'(1) : SW'(0));
        dropped_d = (sum > MAX_S);
        pending_d = dropped_d ? CNT_W'(MAX_PENDING) : sum[CNT_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            frogger_pkg::IDLE: begin
                if (pending_q != '0) state_d = frogger_pkg::ISSUE;
            end
            frogger_pkg::ISSUE: begin
                if (GAP == 0) begin
                    state_d = (sum != '0) ? frogger_pkg::ISSUE : frogger_pkg::IDLE;
                end else begin
                    state_d   = frogger_pkg::GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            frogger_pkg::GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = (pending_q != '0) ? frogger_pkg::ISSUE : frogger_pkg::IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: begin
                state_d   = frogger_pkg::IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        tens_d = tens_q;
        if (overflow && (tens_q != TENS_TOP)) tens_d = tens_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= frogger_pkg::IDLE;
            pending_q <= '0;
            gap_cnt_q <= '0;
            tens_q    <= '0;
            dropped_q <= 1'b0;
        end else if (clear) begin
            state_q   <= frogger_pkg::IDLE;
            pending_q <= '0;
            gap_cnt_q <= '0;
            tens_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            gap_cnt_q <= gap_cnt_d;
            tens_q    <= tens_d;
            dropped_q <= dropped_d;
        end
    end

    assign point   = (state_q == frogger_pkg::ISSUE);
    assign busy    = (state_q != frogger_pkg::IDLE) || (pending_q != '0);
    assign pending = pending_q;
    assign tens    = tens_q;
    assign maxed   = (tens_q == TENS_TOP);
    assign dropped = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_point_issuer.sv
//------------------------------------------------------------------------------
// tb_point_issuer : scoreboard bench for point_issuer (default parameters).
// Revision        : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_point_issuer;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       goal;
    logic       bonus;
    logic       overflow;
    logic       point;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] tens;
    logic       maxed;
    logic       dropped;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int drop_cnt = 0;
    int exp_q[$];

    point_issuer dut (
        .clk      (clk),
        .reset    (rst_n),
        .clear    (clear),
        .goal     (goal),
        .bonus    (bonus),
        .overflow (overflow),
        .point    (point),
        .busy     (busy),
        .pending  (pending),
        .tens     (tens),
        .maxed    (maxed),
        .dropped  (dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every point pulse must match the next scheduled cycle in the scoreboard.
    always @(negedge clk) begin
        if (point) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_point", cyc, -1);
            end else begin
                check_eq("point_cycle", cyc, exp_q.pop_front());
            end
        end
        if (dropped) drop_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic drain(input int k);
        repeat (k) step();
        check_eq("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int d0;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        goal     = 1'b0;
        bonus    = 1'b0;
        overflow = 1'b0;
        #12;
        check_eq("rst_point",   int'(point),   0);
        check_eq("rst_busy",    int'(busy),    0);
        check_eq("rst_pending", int'(pending), 0);
        check_eq("rst_tens",    int'(tens),    0);
        check_eq("rst_maxed",   int'(maxed),   0);
        check_eq("rst_dropped", int'(dropped), 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single goal held high for 10 cycles credits exactly once.
        goal = 1'b1;
        n = cyc + 1;
        exp_q.push_back(n + 1);
        step();
        check_eq("goal_pending1", int'(pending), 1);
        wait_to(n + 3);
        check_eq("goal_busy_gap", int'(busy), 1);
        step();
        check_eq("goal_busy_low", int'(busy), 0);
        check_eq("goal_pending0", int'(pending), 0);
        wait_to(n + 9);
        goal = 1'b0;
        drain(30);

        // One bonus pulse gives three pulses spaced by three cycles.
        d0 = drop_cnt;
        bonus = 1'b1;
        n = cyc + 1;
        for (int i = 0; i < 3; i++) exp_q.push_back(n + 1 + 3 * i);
        step();
        bonus = 1'b0;
        check_eq("bonus_pending3", int'(pending), 3);
        drain(30);
        check_eq("bonus_no_drop", drop_cnt - d0, 0);

        // Goal rise and bonus on the same edge both count.
        goal  = 1'b1;
        bonus = 1'b1;
        n = cyc + 1;
        for (int i = 0; i < 4; i++) exp_q.push_back(n + 1 + 3 * i);
        step();
        bonus = 1'b0;
        goal  = 1'b0;
        check_eq("simul_pending4", int'(pending), 4);
        drain(40);

        // Six back-to-back bonuses: 18 credits, one clipped at the last edge.
        d0 = drop_cnt;
        n = cyc + 1;
        for (int i = 0; i < 17; i++) exp_q.push_back(n + 1 + 3 * i);
        bonus = 1'b1;
        repeat (6) step();
        bonus = 1'b0;
        check_eq("sat_pending15", int'(pending), 15);
        drain(70);
        check_eq("sat_drop_count", drop_cnt - d0, 1);

        // Tens saturates at nine; maxed follows.
        overflow = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check_eq("tens_value", int'(tens), (i > 9) ? 9 : i);
            check_eq("tens_maxed", int'(maxed), (i >= 9) ? 1 : 0);
        end
        overflow = 1'b0;

        // Clear while in GAP with five credits queued; overflow is discarded.
        bonus = 1'b1;
        n = cyc + 1;
        exp_q.push_back(n + 1);
        step();
        step();
        bonus = 1'b0;
        step();
        check_eq("clr_pre_pending5", int'(pending), 5);
        check_eq("clr_pre_gap", int'(point), 0);
        clear    = 1'b1;
        overflow = 1'b1;
        step();
        clear    = 1'b0;
        overflow = 1'b0;
        check_eq("clr_pending", int'(pending), 0);
        check_eq("clr_busy",    int'(busy),    0);
        check_eq("clr_tens",    int'(tens),    0);
        check_eq("clr_maxed",   int'(maxed),   0);
        drain(20);

        // Asynchronous reset between edges in the same situation.
        overflow = 1'b1;
        repeat (2) step();
        overflow = 1'b0;
        check_eq("ar_pre_tens", int'(tens), 2);
        bonus = 1'b1;
        n = cyc + 1;
        exp_q.push_back(n + 1);
        step();
        step();
        bonus = 1'b0;
        step();
        check_eq("ar_pre_pending5", int'(pending), 5);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("ar_point",   int'(point),   0);
        check_eq("ar_busy",    int'(busy),    0);
        check_eq("ar_pending", int'(pending), 0);
        check_eq("ar_tens",    int'(tens),    0);
        rst_n = 1'b1;
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/point_issuer.md
Name: point_issuer

Overview:
- Producer side of the scoreboard point interface.
- Turns game events (frog reaching the goal row, bonus pickups) into correctly spaced single-cycle point pulses for the scoreboard digit counter.
- Consumes the scoreboard's overflow pulse to keep a binary tens count.
- Sits between the frog/lane game logic and the scoreboard; buffers credits so no event is lost while pulses are being issued.

Parameters:
- PTS_PER_GOAL, 1, points credited per goal rising edge (1..MAX_PENDING).
- BONUS_PTS, 3, points credited per bonus pulse (1..MAX_PENDING).
- MAX_PENDING, 15, saturation limit of the pending-credit counter.
- GAP, 2, idle cycles forced between consecutive point pulses (0 allowed).
- CNT_W, 4, width of pending counter; must hold MAX_PENDING.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset (0 = reset).
- clear  input  1  synchronous game restart, active-high.
- goal  input  1  level, high while frog occupies goal row; synchronous to clk.
- bonus  input  1  single-cycle bonus event.
- overflow  input  1  scoreboard carry pulse (ones digit 9->0).
- point  output  1  single-cycle increment pulse to scoreboard.
- busy  output  1  high when state != IDLE or pending != 0.
- pending  output  CNT_W  credits not yet issued.
- tens  output  4  binary tens count 0..9, saturating.
- maxed  output  1  high when tens == 9.
- dropped  output  1  single-cycle pulse when credits were lost to saturation.

Behaviour:
- Reset (reset=0, asynchronous) and clear (synchronous, next edge) produce the same state:
  - state=IDLE, pending=0, goal_q=0, gap_cnt=0, tens=0, dropped=0.
  - Outputs: point=0, busy=0, maxed=0.
- Clear has priority over all other inputs in its cycle.
- Goal edge detect:
  - goal_q <= goal every cycle.
  - goal_rise = goal & ~goal_q.
  - A level held high credits once only.
- Credit add per cycle: add = (goal_rise ? PTS_PER_GOAL : 0) + (bonus ? BONUS_PTS : 0).
  - Goal rise and bonus in the same cycle both count.
- Pending update per edge: pending <= min(pending + add - dec, MAX_PENDING).
  - dec = 1 in the ISSUE cycle, else 0.
  - Compute in CNT_W+2 bits so nothing wraps before the saturation compare.
- dropped is registered and pulses one cycle after any edge where the unsaturated sum exceeded MAX_PENDING.
- FSM, states IDLE, ISSUE, GAP:
  - IDLE: if pending != 0, go to ISSUE.
  - ISSUE: point=1 (Moore decode of the state register, glitch-free); pending decrements. Next state:
    - GAP==0 and pending-1+add != 0 -> ISSUE;
    - GAP==0 otherwise -> IDLE;
    - GAP>0 -> GAP with gap_cnt loaded to GAP-1.
  - GAP: point=0. gap_cnt decrements. When gap_cnt==0:
    - next is ISSUE if pending != 0;
    - otherwise IDLE.
- Latency:
  - goal sampled high at edge N (goal_q low) -> pending=1 after N -> ISSUE after edge N+1 -> point high during cycle N+1..N+2.
  - With GAP=2, pulse spacing is 3 cycles, so 3 credits give point high in cycles 0, 3, 6.
- Tens counting:
  - overflow high at an edge -> tens <= tens+1, holding at 9.
  - maxed = (tens==9), combinational from the register.
- An overflow coinciding with clear is discarded.
- Credits arriving during ISSUE or GAP are queued and never interrupt the spacing.

Decomposition:
- Shared package frogger_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, GAP} issuer_state_t;
  - constant TENS_MAX = 9.
- One natural sub-module: edge_rise (goal_q register plus rise detect, async active-low reset), reusable for other game event inputs.
- Everything else stays in point_issuer.

Test Plan:
- Single goal: defaults, goal held high 10 cycles -> exactly one point pulse, 2 cycles after the sampling edge; pending 1->0; busy low 3 cycles after the pulse.
- Bonus burst: one bonus pulse -> pending=3; point in cycles t, t+3, t+6; no further pulses; dropped never asserts.
- Simultaneous events: goal rise and bonus on the same edge -> pending=4; 4 pulses spaced 3 cycles apart.
- Saturation: 6 bonus pulses on consecutive cycles while pending starts at 0 -> pending clamps at 15; dropped pulses once per clipping edge; exactly 15 point pulses follow.
- Tens: 10 overflow pulses -> tens counts 1..9 and stays 9; maxed rises on the 9th pulse.
- Reset/clear mid-operation: in GAP with pending=5, assert clear -> next edge gives IDLE, pending=0, tens=0, no further point. Repeat with reset=0 asynchronously between edges -> outputs zero immediately without a clock edge.
